// File: rtl/dmux_pkg.sv
// Shared types and helpers for the registered 1-to-4 demultiplexer.
// Provides lane count, select width, select type and one-hot decode.
package dmux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] dmux_sel_t;

  function automatic logic [NUM_OUT-1:0] onehot4(
    input dmux_sel_t s
  );
    logic [NUM_OUT-1:0] oh;
    oh = '0;
    unique case (s)
      2'd0: oh = 4'b0001;
      2'd1: oh = 4'b0010;
      2'd2: oh = 4'b0100;
      2'd3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dmux_lane.sv
// One demux output register: loads d when ld=1, else clears (or holds
// when DMUX_HOLD_EN is defined). Ports: clk, rst_n, ld, d -> q.
module dmux_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = d;
    if (!ld) begin
`ifdef DMUX_HOLD_EN
      q_nxt = q;
`else
      q_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end

endmodule

// File: rtl/dmux_1to4.sv
// Registered 1-to-4 demux: i -> y[sel] one cycle later, y_valid one-hot.
// Ports: clk, rst_n, sel, i, in_valid -> y0..y3, y_valid. Macro: DMUX_HOLD_EN.
module dmux_1to4
  import dmux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid
);

  logic [NUM_OUT-1:0] en;

  always_comb begin
    en = '0;
    if (in_valid) en = onehot4(dmux_sel_t'(sel));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_valid <= '0;
    else        y_valid <= en;
  end

  dmux_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk(clk), .rst_n(rst_n),
    .ld(en[0]), .d(i), .q(y0)
  );

  dmux_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk(clk), .rst_n(rst_n),
    .ld(en[1]), .d(i), .q(y1)
  );

  dmux_lane #(.WIDTH(WIDTH)) u_lane2 (
    .clk(clk), .rst_n(rst_n),
    .ld(en[2]), .d(i), .q(y2)
  );

  dmux_lane #(.WIDTH(WIDTH)) u_lane3 (
    .clk(clk), .rst_n(rst_n),
    .ld(en[3]), .d(i), .q(y3)
  );

endmodule

// File: tb/tb_dmux_1to4.sv
// Directed bench for dmux_1to4 with WIDTH=1 and WIDTH=8 instances.
// Honours DMUX_HOLD_EN for idle/unselected lane expectations.
module tb_dmux_1to4;

`ifdef DMUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] sel;
  logic       in_valid;
  logic [7:0] i8;
  logic [0:0] i1;

  logic [7:0] a0, a1, a2, a3;
  logic [3:0] yv8;
  logic [0:0] b0, b1, b2, b3;
  logic [3:0] yv1;

  logic [7:0] y8 [4];
  logic [0:0] y1 [4];

  logic [7:0] ex [4];
  logic [3:0] exv;

  int n_chk;
  int n_pass;

  assign i1 = i8[0];
  assign y8[0] = a0;
  assign y8[1] = a1;
  assign y8[2] = a2;
  assign y8[3] = a3;
  assign y1[0] = b0;
  assign y1[1] = b1;
  assign y1[2] = b2;
  assign y1[3] = b3;

  dmux_1to4 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .sel(sel), .i(i8),
    .in_valid(in_valid),
    .y0(a0), .y1(a1), .y2(a2), .y3(a3),
    .y_valid(yv8)
  );

  dmux_1to4 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .sel(sel), .i(i1),
    .in_valid(in_valid),
    .y0(b0), .y1(b1), .y2(b2), .y3(b3),
    .y_valid(yv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      assert ($onehot0(yv8))
        else $error("yv8 not one-hot-or-zero");
      assert ($onehot0(yv1))
        else $error("yv1 not one-hot-or-zero");
      assert (!(in_valid && $isunknown(sel)))
        else $error("X on sel with in_valid");
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".yv8"}, 32'(yv8), 32'(exv));
    chk({tag, ".yv1"}, 32'(yv1), 32'(exv));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.y8_%0d", tag, k),
          32'(y8[k]), 32'(ex[k]));
      chk($sformatf("%s.y1_%0d", tag, k),
          32'(y1[k]), 32'(ex[k][0]));
    end
  endtask

  task automatic mdl_clear();
    exv = 4'b0000;
    for (int k = 0; k < 4; k++) ex[k] = 8'h00;
  endtask

  task automatic step(
    input string      tag,
    input bit         v,
    input logic [1:0] s,
    input logic [7:0] d
  );
    in_valid = v;
    sel      = s;
    i8       = d;
    @(posedge clk);
    exv = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (v && int'(s) == k) begin
        ex[k]  = d;
        exv[k] = 1'b1;
      end else if (!HOLD) begin
        ex[k] = 8'h00;
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 2'b00;
    i8       = 8'h00;
    mdl_clear();

    repeat (2) @(posedge clk);
    #1;
    chk_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    step("pre", 1'b1, 2'b01, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    mdl_clear();
    chk_all("arst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      logic [2:0] vec;
      vec = 3'(n);
      step($sformatf("swp%0d", n), 1'b1,
           vec[2:1], {7'h00, vec[0]});
    end

    step("b2b0", 1'b1, 2'b00, 8'h01);
    step("b2b1", 1'b1, 2'b11, 8'h01);

    step("idl0", 1'b1, 2'b10, 8'h01);
    step("idl1", 1'b0, 2'b01, 8'hff);
    chk("idl.y2", 32'(a2), HOLD ? 32'h1 : 32'h0);

    step("w8", 1'b1, 2'b01, 8'ha5);
    chk("w8.y1", 32'(a1), 32'ha5);

    for (int n = 0; n < 300; n++) begin
      bit         v;
      logic [1:0] s;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      step($sformatf("rnd%0d", n), v, s, d);
      if (n == 150) begin
        #2;
        rst_n = 1'b0;
        #1;
        mdl_clear();
        chk_all("mrst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
